// File: rtl/abh.sv
// abh: address-bus-high stage of the 65C02 datapath; drives ADH, holds ABH/PCH/AHH,
// and repairs deferred page crossings with a one-cycle FIX stall.
`default_nettype none

module abh #(
  parameter logic [7:0] RESET_ABH  = 8'hFF,
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       CI,
  input  logic       pcl_co,
  input  logic [7:0] DB,
  input  logic [3:0] op,
  input  logic       ld_ahh,
  input  logic       ld_pc,
  output logic [7:0] ADH,
  output logic [7:0] ABH,
  output logic [7:0] PCH,
  output logic [7:0] AHH,
  output logic       fix
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FIX  = 1'b1
  } state_t;

  localparam logic [1:0] F_INC   = 2'b00;
  localparam logic [1:0] F_STACK = 2'b01;
  localparam logic [1:0] F_ADD   = 2'b10;
  localparam logic [1:0] F_DEFER = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] abh_q, pch_q, ahh_q;
  logic       fix_q;
  logic [7:0] base_w;
  logic [7:0] adh_w;

  always_comb begin
    base_w = 8'h00;
    case (op[3:2])
      2'b00:   base_w = 8'h00;
      2'b01:   base_w = DB;
      2'b10:   base_w = ahh_q;
      default: base_w = pch_q;
    endcase
  end

  // In FIX the previous (uncorrected) high byte is bumped; op and CI are ignored.
  always_comb begin
    adh_w   = base_w;
    state_d = S_IDLE;
    if (state_q == S_FIX) begin
      adh_w = abh_q + 8'd1;
    end else begin
      case (op[1:0])
        F_INC:   adh_w = base_w + {7'd0, CI};
        F_STACK: adh_w = STACK_PAGE;
        F_ADD:   adh_w = base_w + abh_q + {7'd0, CI};
        F_DEFER: begin
          adh_w = base_w;
          if (CI) state_d = S_FIX;
        end
        default: adh_w = base_w;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      fix_q   <= 1'b0;
      abh_q   <= RESET_ABH;
      pch_q   <= 8'h00;
      ahh_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      fix_q   <= (state_d == S_FIX);
      abh_q   <= adh_w;
      if (ld_ahh) ahh_q <= DB;
      // PCH follows the registered ABH, mirroring the low-stage PCL path.
      if (ld_pc) pch_q <= abh_q + {7'd0, pcl_co};
    end
  end

  assign ADH = adh_w;
  assign ABH = abh_q;
  assign PCH = pch_q;
  assign AHH = ahh_q;
  assign fix = fix_q;

endmodule

`default_nettype wire

// File: tb/tb_abh.sv
// tb_abh: randomized scoreboard bench for abh against an arithmetic reference model.
`default_nettype none

module tb_abh;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       CI = 1'b0, pcl_co = 1'b0, ld_ahh = 1'b0, ld_pc = 1'b0;
  logic [7:0] DB = 8'h00;
  logic [3:0] op = 4'h0;
  logic [7:0] ADH, ABH, PCH, AHH;
  logic       fix;

  abh #(.RESET_ABH(8'hFF), .STACK_PAGE(8'h01)) dut (
    .clk(clk), .RST(RST), .CI(CI), .pcl_co(pcl_co), .DB(DB), .op(op),
    .ld_ahh(ld_ahh), .ld_pc(ld_pc), .ADH(ADH), .ABH(ABH), .PCH(PCH),
    .AHH(AHH), .fix(fix)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] tag;
    logic [7:0]  adh, abh, pch, ahh;
    logic        fix;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event sample_now;

  // Reference model state: the architectural registers plus "a fixup is owed".
  int m_abh = 255, m_pch = 0, m_ahh = 0;
  bit m_owed = 0;

  function automatic int model_adh();
    int base;
    if (m_owed) return (m_abh + 1) % 256;
    case (int'(op) / 4)
      0: base = 0;
      1: base = int'(DB);
      2: base = m_ahh;
      default: base = m_pch;
    endcase
    case (int'(op) % 4)
      0: return (base + int'(CI)) % 256;
      1: return 1;
      2: return (base + m_abh + int'(CI)) % 256;
      default: return base;
    endcase
  endfunction

  task automatic push_exp(input logic [63:0] tag);
    exp_t e;
    e.tag = tag;
    e.adh = 8'(model_adh());
    e.abh = 8'(m_abh);
    e.pch = 8'(m_pch);
    e.ahh = 8'(m_ahh);
    e.fix = m_owed;
    sb.push_back(e);
  endtask

  task automatic cmp8(input logic [63:0] tag, input string f, input logic [7:0] a, input logic [7:0] r);
    n_cmp++;
    if (a !== r) begin
      n_bad++;
      $display("FAIL %s.%s got=%02h want=%02h t=%0t", tag, f, a, r, $time);
    end
  endtask

  // Monitor: the DUT presents a result every cycle (sampled at negedge) or on demand.
  always @(negedge clk or sample_now) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp8(e.tag, "ADH", ADH, e.adh);
      cmp8(e.tag, "ABH", ABH, e.abh);
      cmp8(e.tag, "PCH", PCH, e.pch);
      cmp8(e.tag, "AHH", AHH, e.ahh);
      cmp8(e.tag, "fix", {7'd0, fix}, {7'd0, e.fix});
    end
  end

  // One clocked cycle: drive, push expectation, clock, advance model.
  task automatic cyc(input logic [63:0] tag, input logic [3:0] o, input logic c,
                     input logic [7:0] d, input logic la, input logic lp, input logic pc);
    int adh;
    op = o; CI = c; DB = d; ld_ahh = la; ld_pc = lp; pcl_co = pc;
    #1;
    push_exp(tag);
    adh = model_adh();
    @(posedge clk);
    #1;
    if (lp) m_pch = (m_abh + int'(pc)) % 256;
    if (la) m_ahh = int'(d);
    m_owed = !m_owed && (int'(o) % 4 == 3) && c;
    m_abh = adh;
  endtask

  task automatic check_now(input logic [63:0] tag);
    #1;
    push_exp(tag);
    -> sample_now;
    #1;
  endtask

  // Async reset mid-cycle, checked before any clock edge, released after one edge.
  task automatic do_reset(input logic [63:0] tag);
    #2;
    RST = 1'b1;
    m_abh = 255; m_pch = 0; m_ahh = 0; m_owed = 0;
    check_now(tag);
    @(posedge clk);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    op = 4'b0010; CI = 1'b1;
    do_reset("rst0");
    cyc("wrap", 4'b0010, 1, 8'h00, 0, 0, 0);       // FF + 1 -> 00
    cyc("ldahh", 4'b0000, 0, 8'h12, 1, 0, 0);
    cyc("absf", 4'b1000, 1, 8'h00, 0, 0, 0);       // 12 + 1 -> 13
    cyc("abs13", 4'b0000, 0, 8'h00, 0, 0, 0);
    cyc("ld20", 4'b0000, 0, 8'h20, 1, 0, 0);
    cyc("defer", 4'b1011, 1, 8'h00, 0, 0, 0);      // ADH=20, then fixup
    cyc("fixcyc", 4'b0001, 1, 8'h00, 0, 0, 0);     // ADH=21, fix=1
    cyc("postfix", 4'b0000, 0, 8'h00, 0, 0, 0);
    cyc("defnc", 4'b1011, 0, 8'h00, 0, 0, 0);
    cyc("nofix", 4'b0000, 0, 8'h00, 0, 0, 0);
    cyc("abh3f", 4'b0100, 0, 8'h3F, 0, 0, 0);
    cyc("pcinc", 4'b0000, 0, 8'h00, 0, 1, 1);
    cyc("pch40", 4'b0000, 0, 8'h00, 0, 0, 0);
    cyc("abhff", 4'b0100, 0, 8'hFF, 0, 0, 0);
    cyc("pcwrap", 4'b0000, 0, 8'h00, 0, 1, 1);
    cyc("pch00", 4'b0000, 0, 8'h00, 0, 0, 0);
    cyc("abh05", 4'b0100, 0, 8'h05, 0, 0, 0);
    cyc("stack", 4'b0001, 1, 8'hAA, 1, 1, 0);      // ADH=01, AHH<=AA, PCH<=05
    cyc("both", 4'b0000, 0, 8'h00, 0, 0, 0);
    cyc("defer2", 4'b1011, 1, 8'h00, 0, 0, 0);
    check_now("infix");
    do_reset("rstfix");
    cyc("afterrst", 4'b0010, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rrst");
      end else begin
        cyc("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
